psel_gen_prio: RTL and testbench
================================

// Module: psel_gen_prio
// PURPOSE
//  Parametric multi-grant priority selector. Takes a WIDTH-bit request vector and grants up to
//  REQS requests per cycle, highest index first. Used by fetch to pick the next-PC source
//  (WIDTH=2, REQS=1: bit1 branch predictor beats bit0 PC+4), and reusable wherever one-hot arbitration is needed.
// PARAMETERS
//  WIDTH  2  number of request lines (>=1)
//  REQS   1  max simultaneous grants per cycle (1..WIDTH)
// PORTS
//  clock    in   1           system clock; one clock domain
//  reset    in   1           asynchronous, active-low reset (asserted when 0)
//  req      in   WIDTH       request vector, bit i = requester i
//  gnt      out  WIDTH       OR of all grants issued this cycle
//  gnt_bus  out  REQS*WIDTH  slice k ([k*WIDTH +: WIDTH]) = one-hot grant k, or 0 if unused
//  empty    out  1           1 when req == 0
// BEHAVIOUR
//  - Grant k (k=0..REQS-1) goes to the (k+1)-th highest set bit of req; slice 0 = highest index.
//  - Each gnt_bus slice is one-hot or all-zero; slices are pairwise disjoint; gnt = OR of slices.
//  - gnt is a subset of req; popcount(gnt) = min(popcount(req), REQS).
//  - Fewer than REQS requests: remaining upper slices are 0.
//  - req == 0: gnt=0, gnt_bus=0, empty=1.
//  - REQS == WIDTH: gnt == req.
//  - Unknown/X on req is not filtered; a proper implementation uses no latches.
//  - Default (macro off): all outputs purely combinational from req, zero latency;
//    clock/reset are accepted but unused (lint waiver required).
// CONFIGURATION
//  PSEL_GEN_REG_OUT_EN defined: gnt, gnt_bus, empty are registered on posedge clock; 1-cycle latency
//    from req. Reset (async, reset==0) forces gnt=0, gnt_bus=0, empty=1 immediately and holds them
//    until the first rising edge after deassertion. Reset mid-operation discards the pending grant.
//  PSEL_GEN_REG_OUT_EN undefined: combinational behaviour above; no flops inferred.
// STRUCTURE
//  - Sub-module psel_gen_stage: WIDTH-bit highest-set-bit finder; outputs a one-hot grant and
//    remaining = req & ~grant. REQS instances are chained via generate; stage k feeds stage k+1.
//  - No shared typedefs; no package required. Widths are derived locally from WIDTH/REQS.
// TESTING
//  1. WIDTH=2,REQS=1: req=2'b11 -> gnt=2'b10, gnt_bus=2'b10, empty=0; req=2'b01 -> gnt=2'b01.
//  2. WIDTH=2,REQS=1: req=2'b00 -> gnt=0, gnt_bus=0, empty=1.
//  3. WIDTH=8,REQS=2: req=8'b0101_0010 -> gnt_bus[7:0]=8'b0100_0000,
//     gnt_bus[15:8]=8'b0001_0000, gnt=8'b0101_0000.
//  4. WIDTH=8,REQS=3: req=8'b0000_0100 -> slice0=8'b0000_0100, slices 1,2=0, gnt=8'b0000_0100.
//  5. WIDTH=4,REQS=4: random req over 1000 cycles -> gnt==req, slices disjoint one-hot.
//  6. PSEL_GEN_REG_OUT_EN, WIDTH=2: hold reset=0 -> empty=1,gnt=0; release, req=2'b11 ->
//     gnt=2'b10 one edge later; drop reset=0 mid-run -> outputs clear without waiting for clock.

Source files
------------

// File: rtl/psel_gen_stage.sv
// One arbitration stage: finds the highest set bit of i_req, returns it one-hot and the
// requests left over for the next stage.
module psel_gen_stage #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [WIDTH-1:0] o_grant,
   output logic [WIDTH-1:0] o_remaining
);

   localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

   // NOTE: o_grant gets its default before the loop, so every path assigns it and no latch is inferred.
   always_comb begin
      o_grant = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_req[i]) o_grant = LP_ONE << i;
      end
   end

   assign o_remaining = i_req & ~o_grant;

endmodule

// File: rtl/psel_gen_prio.sv
// Multi-grant priority selector: up to REQS one-hot grants per cycle, highest index first.
// Optional output registers when PSEL_GEN_REG_OUT_EN is defined (otherwise purely combinational).
module psel_gen_prio #(
   parameter int WIDTH = 2,
   parameter int REQS  = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      req,
   output logic [WIDTH-1:0]      gnt,
   output logic [REQS*WIDTH-1:0] gnt_bus,
   output logic                  empty
);

   logic [(REQS+1)*WIDTH-1:0] w_remain;
   logic [REQS*WIDTH-1:0]     w_gnt_bus;
   logic [WIDTH-1:0]          w_gnt;
   logic                      w_empty;
   logic                      w_unused_tail;

   assign w_remain[0 +: WIDTH] = req;

   // Stage k sees only the requests not already taken by stages 0..k-1.
   genvar k;
   generate
      for (k = 0; k < REQS; k++) begin : g_stage
         psel_gen_stage #(.WIDTH(WIDTH)) u_stage (
            .i_req       (w_remain[k*WIDTH +: WIDTH]),
            .o_grant     (w_gnt_bus[k*WIDTH +: WIDTH]),
            .o_remaining (w_remain[(k+1)*WIDTH +: WIDTH])
         );
      end
   endgenerate

   assign w_unused_tail = ^w_remain[REQS*WIDTH +: WIDTH];

   always_comb begin
      w_gnt = '0;
      for (int s = 0; s < REQS; s++) w_gnt = w_gnt | w_gnt_bus[s*WIDTH +: WIDTH];
   end

   assign w_empty = ~|req;

`ifdef PSEL_GEN_REG_OUT_EN
   logic [WIDTH-1:0]      r_gnt;
   logic [REQS*WIDTH-1:0] r_gnt_bus;
   logic                  r_empty;

   // NOTE: state uses non-blocking assignments; reset clears outputs asynchronously, so a
   // grant computed before reset is dropped rather than released afterwards.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_gnt     <= '0;
         r_gnt_bus <= '0;
         r_empty   <= 1'b1;
      end else begin
         r_gnt     <= w_gnt;
         r_gnt_bus <= w_gnt_bus;
         r_empty   <= w_empty;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_bus = r_gnt_bus;
   assign empty   = r_empty;
`else
   logic w_unused_clk_rst;
   assign w_unused_clk_rst = clock ^ reset;

   assign gnt     = w_gnt;
   assign gnt_bus = w_gnt_bus;
   assign empty   = w_empty;
`endif

endmodule

// File: tb/tb_psel_gen_prio.sv
// Directed bench for psel_gen_prio over several WIDTH/REQS configurations; works with and
// without PSEL_GEN_REG_OUT_EN (outputs are sampled one edge after req is applied).
module tb_psel_gen_prio;

   logic clock;
   logic reset;

   logic [1:0]  req_a, gnt_a, bus_a;   logic empty_a;  // WIDTH=2 REQS=1
   logic [7:0]  req_b, gnt_b;          logic [15:0] bus_b;  logic empty_b;  // 8/2
   logic [7:0]  req_c, gnt_c;          logic [23:0] bus_c;  logic empty_c;  // 8/3
   logic [3:0]  req_d, gnt_d;          logic [15:0] bus_d;  logic empty_d;  // 4/4

   int n_checks = 0;
   int n_fail   = 0;

   psel_gen_prio #(.WIDTH(2), .REQS(1)) u_dut_a (
      .clock(clock), .reset(reset), .req(req_a), .gnt(gnt_a), .gnt_bus(bus_a), .empty(empty_a));
   psel_gen_prio #(.WIDTH(8), .REQS(2)) u_dut_b (
      .clock(clock), .reset(reset), .req(req_b), .gnt(gnt_b), .gnt_bus(bus_b), .empty(empty_b));
   psel_gen_prio #(.WIDTH(8), .REQS(3)) u_dut_c (
      .clock(clock), .reset(reset), .req(req_c), .gnt(gnt_c), .gnt_bus(bus_c), .empty(empty_c));
   psel_gen_prio #(.WIDTH(4), .REQS(4)) u_dut_d (
      .clock(clock), .reset(reset), .req(req_d), .gnt(gnt_d), .gnt_bus(bus_d), .empty(empty_d));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference for the 4/4 case: slice k holds the (k+1)-th highest set bit.
   function automatic logic [15:0] model_bus4(input logic [3:0] r);
      logic [15:0] res;
      int          rank;
      res  = '0;
      rank = 0;
      for (int i = 3; i >= 0; i--) begin
         if (r[i]) begin
            res[rank*4 + i] = 1'b1;
            rank++;
         end
      end
      return res;
   endfunction

   initial begin
      reset = 1'b0;
      req_a = 2'b11;
      req_b = '0;
      req_c = '0;
      req_d = '0;

      // Reset held from time 0, before any clock edge.
      #3;
`ifdef PSEL_GEN_REG_OUT_EN
      check("rst_gnt_a",   32'(gnt_a),   32'h0);
      check("rst_bus_a",   32'(bus_a),   32'h0);
      check("rst_empty_a", 32'(empty_a), 32'h1);
      check("rst_empty_b", 32'(empty_b), 32'h1);
      tick();
      check("rst_hold_gnt_a",   32'(gnt_a),   32'h0);
      check("rst_hold_empty_a", 32'(empty_a), 32'h1);
`else
      check("rst_gnt_a",   32'(gnt_a),   32'h2);
      check("rst_bus_a",   32'(bus_a),   32'h2);
      check("rst_empty_a", 32'(empty_a), 32'h0);
      check("rst_empty_b", 32'(empty_b), 32'h1);
      tick();
`endif
      reset = 1'b1;

      // Vector 1
      req_a = 2'b11; req_b = 8'b0101_0010; req_c = 8'b0000_0100;
      tick();
      check("a11_gnt",   32'(gnt_a),   32'h2);
      check("a11_bus",   32'(bus_a),   32'h2);
      check("a11_empty", 32'(empty_a), 32'h0);
      check("b52_bus",   32'(bus_b),   32'h1040);
      check("b52_gnt",   32'(gnt_b),   32'h50);
      check("c04_bus",   32'(bus_c),   32'h000004);
      check("c04_gnt",   32'(gnt_c),   32'h04);
      check("c04_empty", 32'(empty_c), 32'h0);

      // Vector 2
      req_a = 2'b01; req_b = 8'hFF; req_c = 8'b1010_1001;
      tick();
      check("a01_gnt", 32'(gnt_a), 32'h1);
      check("a01_bus", 32'(bus_a), 32'h1);
      check("bff_bus", 32'(bus_b), 32'h4080);
      check("bff_gnt", 32'(gnt_b), 32'hC0);
      check("ca9_bus", 32'(bus_c), 32'h082080);
      check("ca9_gnt", 32'(gnt_c), 32'hA8);

      // Vector 3
      req_a = 2'b00; req_b = 8'h01; req_c = 8'h00;
      tick();
      check("a00_gnt",   32'(gnt_a),   32'h0);
      check("a00_bus",   32'(bus_a),   32'h0);
      check("a00_empty", 32'(empty_a), 32'h1);
      check("b01_bus",   32'(bus_b),   32'h0001);
      check("b01_gnt",   32'(gnt_b),   32'h01);
      check("b01_empty", 32'(empty_b), 32'h0);
      check("c00_bus",   32'(bus_c),   32'h0);
      check("c00_empty", 32'(empty_c), 32'h1);

      // Vector 4
      req_a = 2'b10; req_b = 8'h00;
      tick();
      check("a10_gnt",   32'(gnt_a),   32'h2);
      check("b00_gnt",   32'(gnt_b),   32'h0);
      check("b00_bus",   32'(bus_b),   32'h0);
      check("b00_empty", 32'(empty_b), 32'h1);

      // REQS == WIDTH: every request granted, slices ranked by index.
      for (int n = 0; n < 1000; n++) begin
         req_d = 4'($urandom_range(0, 15));
         tick();
         check("d_gnt_eq_req", 32'(gnt_d), 32'(req_d));
         check("d_bus",        32'(bus_d), 32'(model_bus4(req_d)));
         check("d_empty",      32'(empty_d), 32'(req_d == 4'b0));
      end

      // Reset asserted mid-cycle while a grant is live.
      req_a = 2'b11;
      tick();
      check("pre_rst_gnt_a", 32'(gnt_a), 32'h2);
      #2;
      reset = 1'b0;
      #1;
`ifdef PSEL_GEN_REG_OUT_EN
      check("mid_rst_gnt_a",   32'(gnt_a),   32'h0);
      check("mid_rst_bus_a",   32'(bus_a),   32'h0);
      check("mid_rst_empty_a", 32'(empty_a), 32'h1);
      tick();
      check("mid_rst_hold_gnt_a", 32'(gnt_a), 32'h0);
`else
      check("mid_rst_gnt_a",   32'(gnt_a),   32'h2);
      check("mid_rst_empty_a", 32'(empty_a), 32'h0);
      tick();
`endif
      reset = 1'b1;
      req_a = 2'b01;
      tick();
      check("post_rst_gnt_a",   32'(gnt_a),   32'h1);
      check("post_rst_empty_a", 32'(empty_a), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
